fifo_ram_ctrl: RTL and testbench

//  Synchronous FIFO controller that drives both ports of an external dual-port RAM.
//  It generates write/read enables and addresses, tracks occupancy, and returns read data with a valid strobe.
//  It sits between a streaming producer/consumer pair and one dual-port RAM instance of depth 2**ADDR_W.

---
 rtl/fifo_ram_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_ram_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller driving both ports of an external dual-port RAM.
// Define FIFO_ERR_EN to add err_clr and the sticky overflow/underflow flags.
module fifo_ram_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned USE_RAM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
`ifdef FIFO_ERR_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0]   LevelFull = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LevelOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PtrOne    = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push_acc, pop_acc;

  assign empty = (level_q == '0);
  assign full  = (level_q == LevelFull);
  assign level = level_q;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  assign ram_w_en   = push_acc;
  assign ram_w_addr = wr_ptr_q;
  assign ram_w_data = push_data;
  assign ram_r_en   = pop_acc;
  assign ram_r_addr = rd_ptr_q;
  assign pop_data   = ram_r_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  if (USE_RAM != 0) begin : g_reg_read
    // RAM output lands one cycle after the read enable, so the strobe follows it.
    logic pop_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pop_valid_q <= 1'b0;
      else        pop_valid_q <= pop_acc;
    end
    assign pop_valid = pop_valid_q;
  end else begin : g_comb_read
    assign pop_valid = pop_acc;
  end

`ifdef FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Clear takes effect on the next edge, but a fresh error in that cycle wins.
  always_comb begin
    overflow_d  = (overflow_q & ~err_clr) | (push & full & ~pop);
    underflow_d = (underflow_q & ~err_clr) | (pop & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl: one instance with registered RAM read and one
// with combinational read, driven by identical stimulus, each with its own RAM model.
module tb_fifo_ram_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk, rst_n;
  logic          push, pop;
  logic [DW-1:0] push_data;
`ifdef FIFO_ERR_EN
  logic          err_clr;
  logic          ovf1, unf1, ovf0, unf0;
`endif

  // Registered-read instance (suffix 1) and combinational-read instance (suffix 0).
  logic [DW-1:0] pdata1, pdata0, wdata1, wdata0, rdata1, rdata0;
  logic          pvalid1, pvalid0, empty1, empty0, full1, full0;
  logic [AW:0]   level1, level0;
  logic          wen1, wen0, ren1, ren0;
  logic [AW-1:0] waddr1, waddr0, raddr1, raddr0;
  logic [DW-1:0] mem1 [4];
  logic [DW-1:0] mem0 [4];

  int n_chk = 0;
  int n_err = 0;

  fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(1)) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pdata1), .pop_valid(pvalid1), .empty(empty1), .full(full1), .level(level1),
    .ram_w_en(wen1), .ram_w_addr(waddr1), .ram_w_data(wdata1),
    .ram_r_en(ren1), .ram_r_addr(raddr1), .ram_r_data(rdata1)
`ifdef FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf1), .underflow(unf1)
`endif
  );

  fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(0)) u_dut_comb (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pdata0), .pop_valid(pvalid0), .empty(empty0), .full(full0), .level(level0),
    .ram_w_en(wen0), .ram_w_addr(waddr0), .ram_w_data(wdata0),
    .ram_r_en(ren0), .ram_r_addr(raddr0), .ram_r_data(rdata0)
`ifdef FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf0), .underflow(unf0)
`endif
  );

  // Read-before-write dual-port RAM models.
  always @(posedge clk) begin
    if (ren1) rdata1 <= mem1[raddr1];
    if (wen1) mem1[waddr1] <= wdata1;
    if (wen0) mem0[waddr0] <= wdata0;
  end
  assign rdata0 = mem0[raddr0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge with push/pop idle.
  task automatic chk_state(input string tag, input int lvl);
    chk({tag, " level1"}, 32'(level1), 32'(lvl));
    chk({tag, " level0"}, 32'(level0), 32'(lvl));
    chk({tag, " empty1"}, 32'(empty1), 32'(lvl == 0));
    chk({tag, " empty0"}, 32'(empty0), 32'(lvl == 0));
    chk({tag, " full1"},  32'(full1),  32'(lvl == 4));
    chk({tag, " full0"},  32'(full0),  32'(lvl == 4));
  endtask

  task automatic do_cycle(input string tag, input logic ps, input logic [DW-1:0] d,
                          input logic pp, input logic exp_we, input logic exp_v,
                          input logic [DW-1:0] exp_d);
    push = ps; push_data = d; pop = pp;
    #1;
    chk({tag, " wen1"}, 32'(wen1), 32'(exp_we));
    chk({tag, " wen0"}, 32'(wen0), 32'(exp_we));
    chk({tag, " valid0"}, 32'(pvalid0), 32'(exp_v));
    if (exp_v) chk({tag, " data0"}, 32'(pdata0), 32'(exp_d));
    @(posedge clk);
    #1;
    chk({tag, " valid1"}, 32'(pvalid1), 32'(exp_v));
    if (exp_v) chk({tag, " data1"}, 32'(pdata1), 32'(exp_d));
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
  endtask

`ifdef FIFO_ERR_EN
  task automatic clr_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
`ifdef FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk_state("reset", 0);
    chk("reset valid1", 32'(pvalid1), 32'(0));
    chk("reset valid0", 32'(pvalid0), 32'(0));
`ifdef FIFO_ERR_EN
    chk("reset ovf1", 32'(ovf1), 32'(0));
    chk("reset unf0", 32'(unf0), 32'(0));
`endif

    // 1: fill then drain in order
    do_cycle("fill", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill", 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill", 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_state("full", 4);
    do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11);
    do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22);
    do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33);
    do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44);
    chk_state("drained", 0);

    // 2: refused push when full
    do_cycle("fill2", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill2", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill2", 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill2", 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("ovf push", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_state("ovf", 4);
`ifdef FIFO_ERR_EN
    chk("ovf set1", 32'(ovf1), 32'(1));
    chk("ovf set0", 32'(ovf0), 32'(1));
    @(negedge clk);
    chk("ovf sticky1", 32'(ovf1), 32'(1));
    clr_err();
    chk("ovf clr1", 32'(ovf1), 32'(0));
    chk("ovf clr0", 32'(ovf0), 32'(0));
`endif
    do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11);
    do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22);
    do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33);
    do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44);
    chk_state("drained2", 0);

    // 3: streaming with pointer wrap, level held at 2
    do_cycle("stream", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("stream", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 2; i < 10; i++) begin
      do_cycle("stream", 1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 8'(i - 2));
    end
    chk_state("stream mid", 2);
    do_cycle("stream", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08);
    do_cycle("stream", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09);
    chk_state("stream end", 0);

    // 4: full with simultaneous push and pop
    do_cycle("fill4", 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill4", 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill4", 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill4", 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("full pp", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hB0);
    chk_state("full pp", 4);
    do_cycle("drain4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB1);
    do_cycle("drain4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB2);
    do_cycle("drain4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB3);
    do_cycle("drain4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA);
    chk_state("drained4", 0);

    // 5: empty with simultaneous push and pop
    do_cycle("empty pp", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00);
    chk_state("empty pp", 1);
`ifdef FIFO_ERR_EN
    chk("unf set1", 32'(unf1), 32'(1));
    chk("unf set0", 32'(unf0), 32'(1));
    clr_err();
    chk("unf clr1", 32'(unf1), 32'(0));
`endif
    do_cycle("pop77", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
    chk_state("pop77", 0);

    // 6: asynchronous reset mid-stream
    do_cycle("fill6", 1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill6", 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill6", 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle("fill6", 1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 8'h00);
    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
    chk("pre-rst valid1", 32'(pvalid1), 32'(1));
    chk("pre-rst data1", 32'(pdata1), 32'(8'hC1));
    chk("pre-rst level1", 32'(level1), 32'(3));
    #1 rst_n = 1'b0;
    #1;
    chk("rst level1", 32'(level1), 32'(0));
    chk("rst level0", 32'(level0), 32'(0));
    chk("rst empty1", 32'(empty1), 32'(1));
    chk("rst empty0", 32'(empty0), 32'(1));
    chk("rst valid1", 32'(pvalid1), 32'(0));
    chk("rst valid0", 32'(pvalid0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("post-rst pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    chk_state("post-rst", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
